simple22_loader: RTL and testbench

Host-side instruction loader and run controller for the Simple22 core. It consumes a byte stream from the UART receiver, assembles little-endian instruction words, and writes them one by one into the core's instruction memory via the core's `new_instruction` / `final_pc` / `new_instruction_available` interface. It also decodes run and stop commands into the core's level-sensitive `execute` input. It sits directly upstream of the core, between the UART RX and the core.

---
 rtl/simple22_loader_pkg.sv | 23 ++
 rtl/simple22_byte_assembler.sv | 53 +++++
 rtl/simple22_loader.sv | 162 ++++++++++++++++
 tb/tb_simple22_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple22_loader_pkg.sv
// Shared definitions for the Simple22 instruction loader: command codes,
// FSM state encoding and default sizes matching the Simple22 core.
package simple22_loader_pkg;

    localparam int ISIZE_DEFAULT        = 32;
    localparam int RSIZE_DEFAULT        = 32;
    localparam int IMEMSIZE_DEFAULT     = 256;
    localparam int TIMEOUT_CLKS_DEFAULT = 1_000_000;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_STOP  = 8'h03;
    localparam logic [7:0] CMD_CLEAR = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_CSUM    = 3'd2,
        S_COMMIT  = 3'd3,
        S_STROBE  = 3'd4
    } state_t;

endpackage

// File: rtl/simple22_byte_assembler.sv
// Little-endian word assembler for LOAD payloads: shift-in holding register,
// payload byte counter and inter-byte timeout counter.
module simple22_byte_assembler #(
    parameter int ISIZE        = 32,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             collect,
    input  logic             active,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic [ISIZE-1:0] word,
    output logic             done,
    output logic             abort
);

    localparam int NBYTES = ISIZE / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (start) begin
            word     <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (collect && rx_valid) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (byte_cnt == BW'(k)) word[8*k +: 8] <= rx_byte;
                end
                byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
            end
            if (!active || rx_valid) tmo_cnt <= '0;
            else                     tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // abort fires in the idle cycle that brings the count to TIMEOUT_CLKS
    assign done  = collect && rx_valid && (byte_cnt == LAST_BYTE);
    assign abort = active && !rx_valid && (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/simple22_loader.sv
// Simple22 host loader: decodes UART command bytes, writes assembled words into
// the core's instruction memory and drives its execute level.
// Optional trailing XOR checksum per frame: define SIMPLE22_LOADER_CSUM_EN.
module simple22_loader
    import simple22_loader_pkg::*;
#(
    parameter int ISIZE        = ISIZE_DEFAULT,
    parameter int RSIZE        = RSIZE_DEFAULT,
    parameter int IMEMSIZE     = IMEMSIZE_DEFAULT,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic [ISIZE-1:0] new_instruction,
    output logic [RSIZE-1:0] final_pc,
    output logic             new_instruction_available,
    output logic             execute,
    output logic [RSIZE-1:0] load_count,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam logic [RSIZE-1:0] LC_MAX = RSIZE'(IMEMSIZE);

    state_t           state, state_nx;
    logic             strobe_second;
    logic [ISIZE-1:0] hold_word;
    logic             asm_done, asm_abort;
    logic             lc_full, start_frame;
    logic             commit, lc_inc, run_ok, stop_cmd, clear_ok, err_set;

    assign lc_full     = (load_count == LC_MAX);
    assign start_frame = (state == S_IDLE) && rx_valid && (rx_byte == CMD_LOAD) && !execute;
    assign state_dbg   = state;

    simple22_byte_assembler #(
        .ISIZE       (ISIZE),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_frame),
        .collect (state == S_PAYLOAD),
        .active  ((state == S_PAYLOAD) || (state == S_CSUM)),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .word    (hold_word),
        .done    (asm_done),
        .abort   (asm_abort)
    );

`ifdef SIMPLE22_LOADER_CSUM_EN
    logic [7:0] csum;
    logic       csum_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              csum <= '0;
        else if (start_frame)                    csum <= CMD_LOAD;
        else if (state == S_PAYLOAD && rx_valid) csum <= csum ^ rx_byte;
    end

    assign csum_ok = (rx_byte == csum);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            strobe_second <= 1'b0;
        end else begin
            state         <= state_nx;
            strobe_second <= (state == S_STROBE) && !strobe_second;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start_frame) state_nx = S_PAYLOAD;
            S_PAYLOAD: begin
                if (asm_abort) state_nx = S_IDLE;
`ifdef SIMPLE22_LOADER_CSUM_EN
                else if (asm_done) state_nx = S_CSUM;
`else
                else if (asm_done) state_nx = lc_full ? S_IDLE : S_COMMIT;
`endif
            end
`ifdef SIMPLE22_LOADER_CSUM_EN
            S_CSUM: begin
                if (asm_abort)     state_nx = S_IDLE;
                else if (rx_valid) state_nx = (csum_ok && !lc_full) ? S_COMMIT : S_IDLE;
            end
`endif
            S_COMMIT:  state_nx = S_STROBE;
            S_STROBE:  if (strobe_second) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        new_instruction_available = (state == S_STROBE);
        commit   = (state == S_COMMIT);
        lc_inc   = (state == S_STROBE) && strobe_second;
        run_ok   = 1'b0;
        stop_cmd = 1'b0;
        clear_ok = 1'b0;
        err_set  = 1'b0;
        if (state == S_IDLE && rx_valid) begin
            case (rx_byte)
                CMD_LOAD:  err_set = execute;
                CMD_RUN:   begin
                    run_ok  = (load_count != '0);
                    err_set = (load_count == '0);
                end
                CMD_STOP:  stop_cmd = 1'b1;
                CMD_CLEAR: begin
                    clear_ok = !execute;
                    err_set  = execute;
                end
                default:   err_set = 1'b1;
            endcase
        end
`ifdef SIMPLE22_LOADER_CSUM_EN
        if (state == S_CSUM && rx_valid && (!csum_ok || lc_full)) err_set = 1'b1;
`else
        if (state == S_PAYLOAD && asm_done && lc_full) err_set = 1'b1;
`endif
        if (asm_abort) err_set = 1'b1;
        if (rx_valid && (state == S_COMMIT || state == S_STROBE)) err_set = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_instruction <= '0;
            final_pc        <= '0;
            execute         <= 1'b0;
            load_count      <= '0;
            err             <= 1'b0;
        end else begin
            if (commit) begin
                new_instruction <= hold_word;
                final_pc        <= load_count;
            end
            if (run_ok)        execute <= 1'b1;
            else if (stop_cmd) execute <= 1'b0;
            if (lc_inc && !lc_full) load_count <= load_count + 1'b1;
            if (clear_ok) begin
                load_count <= '0;
                final_pc   <= '0;
                err        <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Bytes cannot arrive this fast from the UART; flag it if they ever do
    assert property (@(posedge clk) disable iff (!rst_n)
        !(rx_valid && (state == S_COMMIT || state == S_STROBE)));

endmodule

// File: tb/tb_simple22_loader.sv
// Bench for simple22_loader: hand-written corner sequences, a table of command
// steps with fixed expectations, and random traffic against a byte-level model.
module tb_simple22_loader;

  localparam int ISIZE    = 32;
  localparam int RSIZE    = 32;
  localparam int IMEMSIZE = 4;
  localparam int TMO      = 40;
  localparam int NB       = ISIZE / 8;
`ifdef SIMPLE22_LOADER_CSUM_EN
  localparam bit CSUM_EN  = 1'b1;
  localparam int FLEN     = NB + 1;
`else
  localparam bit CSUM_EN  = 1'b0;
  localparam int FLEN     = NB;
`endif

  logic             clk;
  logic             rst_n;
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic [ISIZE-1:0] new_instruction;
  logic [RSIZE-1:0] final_pc;
  logic             nia;
  logic             execute;
  logic [RSIZE-1:0] load_count;
  logic             err;
  logic [2:0]       state_dbg;

  simple22_loader #(
    .ISIZE       (ISIZE),
    .RSIZE       (RSIZE),
    .IMEMSIZE    (IMEMSIZE),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .rx_valid                 (rx_valid),
    .rx_byte                  (rx_byte),
    .new_instruction          (new_instruction),
    .final_pc                 (final_pc),
    .new_instruction_available(nia),
    .execute                  (execute),
    .load_count               (load_count),
    .err                      (err),
    .state_dbg                (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];
  int          m_lc;
  int          m_pc;
  bit          m_exec, m_err, m_in_frame;
  logic [7:0]  m_frame[$];

  function automatic void model_reset();
    m_lc = 0; m_pc = 0; m_exec = 0; m_err = 0; m_in_frame = 0;
    m_frame.delete();
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [31:0] w;
    logic [7:0]  x;
    bit          ok;
    if (m_in_frame) begin
      m_frame.push_back(b);
      if (m_frame.size() == FLEN) begin
        m_in_frame = 0;
        w = '0;
        x = 8'h01;
        for (int k = 0; k < NB; k++) begin
          w = w | (32'(m_frame[k]) << (8 * k));
          x = x ^ m_frame[k];
        end
        ok = !CSUM_EN || (m_frame[FLEN-1] == x);
        if (ok && m_lc < IMEMSIZE) begin
          exp_q.push_back({32'(m_lc), w});
          m_pc = m_lc;
          m_lc = m_lc + 1;
        end else begin
          m_err = 1;
        end
      end
    end else begin
      case (b)
        8'h01: if (m_exec) m_err = 1; else begin m_in_frame = 1; m_frame.delete(); end
        8'h02: if (m_lc > 0) m_exec = 1; else m_err = 1;
        8'h03: m_exec = 0;
        8'h04: if (m_exec) m_err = 1; else begin m_lc = 0; m_pc = 0; m_err = 0; end
        default: m_err = 1;
      endcase
    end
  endfunction

  // ---------------- strobe monitor / scoreboard ----------------
  logic nia_prev = 1'b0;
  int   strobe_len = 0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (nia && !nia_prev) begin
      if (exp_q.size() == 0) check("unexpected_strobe", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("strobe_word", 64'(new_instruction), 64'(e[31:0]));
        check("strobe_pc", 64'(final_pc), 64'(e[63:32]));
      end
      strobe_len = 1;
    end else if (nia) begin
      strobe_len++;
    end else if (nia_prev) begin
      check("strobe_len", 64'(strobe_len), 64'(2));
    end
    nia_prev = nia;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_byte = b;
    model_byte(b);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_byte = 8'h00;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_load(input logic [31:0] w, input bit bad_csum, input int last_gap);
    logic [7:0] x;
    x = 8'h01;
    send_byte(8'h01, $urandom_range(0, 2));
    for (int k = 0; k < NB; k++) begin
      x = x ^ w[8*k +: 8];
      send_byte(w[8*k +: 8], (k == NB - 1 && !CSUM_EN) ? last_gap : $urandom_range(0, 2));
    end
    if (CSUM_EN) send_byte(bad_csum ? (x ^ 8'h5a) : x, last_gap);
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    check({tag, "_lc"}, 64'(load_count), 64'(m_lc));
    check({tag, "_pc"}, 64'(final_pc), 64'(m_pc));
    check({tag, "_exec"}, 64'(execute), 64'(m_exec));
    check({tag, "_err"}, 64'(err), 64'(m_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_nia"}, 64'(nia), 64'(0));
    check({tag, "_instr"}, 64'(new_instruction), 64'(0));
    check({tag, "_pc"}, 64'(final_pc), 64'(0));
    check({tag, "_exec"}, 64'(execute), 64'(0));
    check({tag, "_lc"}, 64'(load_count), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_state"}, 64'(state_dbg), 64'(0));
  endtask

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          lc;
    int          pc;
    bit          ex;
    bit          er;
  } step_t;

  step_t tbl[$];

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rst_n    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset");

    // first LOAD with exact latency: strobe two cycles after COMMIT
    send_load(32'h0000_0201, 1'b0, 0);
    @(negedge clk);
    check("lat_commit_nia", 64'(nia), 64'(0));
    @(negedge clk);
    check("lat_s1_nia", 64'(nia), 64'(1));
    check("lat_s1_instr", 64'(new_instruction), 64'h201);
    check("lat_s1_pc", 64'(final_pc), 64'(0));
    @(negedge clk);
    check("lat_s2_nia", 64'(nia), 64'(1));
    check("lat_s2_lc", 64'(load_count), 64'(0));
    @(negedge clk);
    check("lat_end_nia", 64'(nia), 64'(0));
    check("lat_end_lc", 64'(load_count), 64'(1));

    // table of steps with hand-derived results (IMEMSIZE = 4)
    tbl.push_back('{1'b1, 32'hDEAD_BEEF, 2, 1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h1234_5678, 3, 2, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h02,        3, 2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h01,        3, 2, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 32'h03,        3, 2, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h04,        0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h02,        0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h04,        0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h55,        0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h04,        0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h00,        0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h04,        0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'hA5A5_0001, 1, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h0000_FF02, 2, 1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h8000_0003, 3, 2, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'h7F7F_7F04, 4, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 32'hCAFE_F00D, 4, 3, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h02,        4, 3, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 32'h04,        4, 3, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 32'h03,        4, 3, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h04,        0, 0, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_load) send_load(tbl[i].data, 1'b0, 3);
      else                send_byte(tbl[i].data[7:0], 3);
      @(negedge clk);
      check($sformatf("tbl%0d_lc", i), 64'(load_count), 64'(tbl[i].lc));
      check($sformatf("tbl%0d_pc", i), 64'(final_pc), 64'(tbl[i].pc));
      check($sformatf("tbl%0d_exec", i), 64'(execute), 64'(tbl[i].ex));
      check($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].er));
    end

    // inter-byte timeout in the middle of a frame
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (TMO - 2) @(posedge clk);
    @(negedge clk);
    check("tmo_early_err", 64'(err), 64'(0));
    check("tmo_early_state", 64'(state_dbg), 64'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tmo_err", 64'(err), 64'(1));
    check("tmo_state", 64'(state_dbg), 64'(0));
    m_in_frame = 0;
    m_err = 1;
    send_load(32'h0BAD_F00D, 1'b0, 3);
    check_model("after_tmo");
    check("after_tmo_pc0", 64'(final_pc), 64'(0));

`ifdef SIMPLE22_LOADER_CSUM_EN
    send_load(32'h1122_3344, 1'b0, 3);
    check_model("csum_good");
    check("csum_good_lc", 64'(load_count), 64'(2));
    send_load(32'h1122_3344, 1'b1, 3);
    check_model("csum_bad");
    check("csum_bad_lc", 64'(load_count), 64'(2));
    check("csum_bad_err", 64'(err), 64'(1));
`endif

    // asynchronous reset in the middle of a payload
    send_byte(8'h01, 0);
    send_byte(8'h77, 1);
    @(negedge clk);
    check("pre_rst_state", 64'(state_dbg), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_load(32'h0000_00AA, 1'b0, 3);
    check_model("post_rst");
    check("post_rst_pc0", 64'(final_pc), 64'(0));

    // random command traffic against the model
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        if (m_exec) send_byte(8'h01, 3);
        else send_load($urandom, CSUM_EN && ($urandom_range(0, 3) == 0), 3);
      end else if (r <= 5) send_byte(8'h02, 3);
      else if (r == 6)     send_byte(8'h03, 3);
      else if (r == 7)     send_byte(8'($urandom_range(5, 255)), 3);
      else                 send_byte(8'h04, 3);
      check_model("rnd");
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
